// File: rtl/closest_word_tracker_pkg.sv
// closest_pkg: shared widths and FSM state encoding for the closest-word tracker
package closest_pkg;
  localparam int WIDTH = 8;
  localparam int CNT_W = 4;
  localparam int DIST_W = 4;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/closest_word_tracker_hamming.sv
// hamming_distance: combinational popcount of a ^ b
module hamming_distance
  import closest_pkg::*;
(
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic [DIST_W-1:0] d
);
  always_comb begin
    d = '0;
    for (int i = 0; i < WIDTH; i++) d = d + DIST_W'(a[i] ^ b[i]);
  end
endmodule

// File: rtl/closest_word_tracker.sv
// closest_word_tracker: keeps the candidate with the smallest Hamming distance to a latched reference
module closest_word_tracker
  import closest_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WIDTH-1:0]  ref_in,
  input  logic [CNT_W-1:0]  len,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  in_data,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [WIDTH-1:0]  best_word,
  output logic [DIST_W-1:0] best_dist,
  output logic [CNT_W-1:0]  best_index
);
  state_t state, state_nxt;
  logic [WIDTH-1:0] ref_q;
  logic [CNT_W-1:0] len_q, cnt;
  logic [DIST_W-1:0] d;
  logic acc, last;
  hamming_distance u_hd (.a(ref_q), .b(in_data), .d(d));
  assign in_ready = state == RUN;
  assign acc = in_ready & in_valid;
  assign last = cnt == len_q - CNT_W'(1);
  always_comb begin
    state_nxt = state == IDLE ? (start ? (len == '0 ? DONE : RUN) : IDLE) :
                state == RUN  ? (acc && last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= state_nxt == DONE;
      busy  <= state_nxt != IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_q      <= '0;
      len_q      <= '0;
      cnt        <= '0;
      found      <= 1'b0;
      best_word  <= '0;
      best_dist  <= '0;
      best_index <= '0;
    end else if (state == IDLE && start) begin
      ref_q      <= ref_in;
      len_q      <= len;
      cnt        <= '0;
      found      <= 1'b0;
      best_word  <= '0;
      best_dist  <= '0;
      best_index <= '0;
    end else if (acc) begin
      cnt   <= cnt + CNT_W'(1);
      found <= 1'b1;
      if (cnt == '0 || d < best_dist) begin
        best_word  <= in_data;
        best_dist  <= d;
        best_index <= cnt;
      end
    end
  end
endmodule

// File: tb/tb_closest_word_tracker.sv
// tb_closest_word_tracker: directed and randomized checks of the closest-word tracker against a reference model
module tb_closest_word_tracker;
  logic clk = 0, rst = 1, start = 0, in_valid = 0;
  logic [7:0] ref_in = 0, in_data = 0;
  logic [3:0] len = 0;
  logic in_ready, busy, done, found;
  logic [7:0] best_word;
  logic [3:0] best_dist, best_index;
  logic [7:0] w[16];
  int nvec = 0, nerr = 0;
  int cyc = 0, done_cyc = -1, done_n = 0, ready_n = 0;
  closest_word_tracker dut (
    .clk(clk), .rst(rst), .start(start), .ref_in(ref_in), .len(len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .busy(busy),
    .done(done), .found(found), .best_word(best_word), .best_dist(best_dist),
    .best_index(best_index)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc++;
    #1;
    if (done) begin
      done_cyc = cyc;
      done_n++;
    end
    if (in_ready) ready_n++;
  end
  task automatic model(input logic [7:0] r, input int n, output logic [7:0] ew,
                       output logic [3:0] ed, output logic [3:0] ei, output logic ef);
    int bd = 99;
    ew = 0; ed = 0; ei = 0; ef = n != 0;
    for (int i = 0; i < n; i++)
      if ($countones(r ^ w[i]) < bd) begin
        bd = $countones(r ^ w[i]);
        ew = w[i]; ed = 4'(bd); ei = 4'(i);
      end
  endtask
  task automatic run(input logic [7:0] r, input int n, input int gap, input bit poke, output int lat);
    int st;
    done_cyc = -1; done_n = 0; ready_n = 0;
    @(negedge clk); start = 1; ref_in = r; len = 4'(n); st = cyc + 1;
    @(negedge clk); start = 0; ref_in = 8'($urandom); len = 4'($urandom);
    for (int i = 0; i < n; i++) begin
      in_valid = 1; in_data = w[i];
      start = poke && i == 1; ref_in = ~r; len = 4'd7;
      @(negedge clk);
      in_valid = 0; start = 0; in_data = 8'($urandom);
      if (i < n - 1) repeat (gap) @(negedge clk);
    end
    for (int k = 0; k < 20 && done_cyc < 0; k++) @(negedge clk);
    lat = done_cyc < 0 ? -1 : done_cyc - st + 1;
    @(negedge clk);
  endtask
  task automatic test_reset;
    rst = 1;
    repeat (3) @(negedge clk);
    nvec++;
    if ({done, busy, found, in_ready, best_word, best_dist, best_index} !== 0) begin
      nerr++; $display("FAIL reset: outputs=%h required 0", {done, busy, found, in_ready, best_word, best_dist, best_index});
    end
    rst = 0;
  endtask
  task automatic test_tie;
    int lat;
    w[0] = 8'h56; w[1] = 8'h35;
    run(8'h6F, 2, 0, 0, lat);
    nvec++;
    if ({best_word, best_dist, best_index, found} !== {8'h56, 4'd4, 4'd0, 1'b1}) begin
      nerr++; $display("FAIL tie: word=%h dist=%0d idx=%0d found=%b required 56/4/0/1", best_word, best_dist, best_index, found);
    end
    nvec++;
    if (lat !== 3) begin nerr++; $display("FAIL tie_latency: got %0d required 3", lat); end
  endtask
  task automatic test_min;
    int lat;
    w[0] = 8'hFF; w[1] = 8'h0F; w[2] = 8'h01; w[3] = 8'h03;
    run(8'h00, 4, 0, 0, lat);
    nvec++;
    if ({best_word, best_dist, best_index, found} !== {8'h01, 4'd1, 4'd2, 1'b1}) begin
      nerr++; $display("FAIL min: word=%h dist=%0d idx=%0d found=%b required 01/1/2/1", best_word, best_dist, best_index, found);
    end
    nvec++;
    if (lat !== 5) begin nerr++; $display("FAIL min_latency: got %0d required 5", lat); end
    nvec++;
    if (done_n !== 1) begin nerr++; $display("FAIL min_done_pulse: got %0d pulses required 1", done_n); end
  endtask
  task automatic test_backpressure;
    int lat;
    w[0] = 8'h12; w[1] = 8'hA5; w[2] = 8'h5A;
    run(8'hA5, 3, 2, 0, lat);
    nvec++;
    if ({best_word, best_dist, best_index} !== {8'hA5, 4'd0, 4'd1}) begin
      nerr++; $display("FAIL backpressure: word=%h dist=%0d idx=%0d required a5/0/1", best_word, best_dist, best_index);
    end
    nvec++;
    if (lat !== 8) begin nerr++; $display("FAIL backpressure_latency: got %0d required 8", lat); end
  endtask
  task automatic test_empty;
    int lat;
    run(8'h77, 0, 0, 0, lat);
    nvec++;
    if ({found, best_word, best_dist, best_index} !== 0) begin
      nerr++; $display("FAIL empty: found=%b word=%h dist=%0d idx=%0d required all 0", found, best_word, best_dist, best_index);
    end
    nvec++;
    if (lat !== 1 || done_n !== 1) begin nerr++; $display("FAIL empty_done: latency %0d pulses %0d required 1/1", lat, done_n); end
    nvec++;
    if (ready_n !== 0) begin nerr++; $display("FAIL empty_ready: in_ready high %0d cycles required 0", ready_n); end
  endtask
  task automatic test_reset_mid;
    int lat;
    @(negedge clk); start = 1; ref_in = 8'h3C; len = 4'd5;
    @(negedge clk); start = 0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1; in_data = 8'h3C ^ 8'(i);
      @(negedge clk);
    end
    rst = 1; start = 1;
    @(negedge clk);
    nvec++;
    if ({done, busy, found, in_ready, best_word, best_dist, best_index} !== 0) begin
      nerr++; $display("FAIL reset_mid: outputs=%h required 0", {done, busy, found, in_ready, best_word, best_dist, best_index});
    end
    rst = 0; start = 0;
    @(negedge clk);
    nvec++;
    if ({in_ready, busy} !== 2'b00) begin nerr++; $display("FAIL reset_mid_idle: ready/busy=%b required 00", {in_ready, busy}); end
    in_valid = 0;
    w[0] = 8'hF1;
    run(8'hF0, 1, 0, 0, lat);
    nvec++;
    if ({best_word, best_dist, best_index, found} !== {8'hF1, 4'd1, 4'd0, 1'b1}) begin
      nerr++; $display("FAIL reset_mid_fresh: word=%h dist=%0d idx=%0d found=%b required f1/1/0/1", best_word, best_dist, best_index, found);
    end
  endtask
  task automatic test_start_busy;
    int lat;
    logic [7:0] ew; logic [3:0] ed, ei; logic ef;
    for (int i = 0; i < 4; i++) w[i] = 8'($urandom);
    model(8'h3C, 4, ew, ed, ei, ef);
    run(8'h3C, 4, 1, 1, lat);
    nvec++;
    if ({best_word, best_dist, best_index, found} !== {ew, ed, ei, ef}) begin
      nerr++; $display("FAIL start_busy: word=%h dist=%0d idx=%0d required %h/%0d/%0d", best_word, best_dist, best_index, ew, ed, ei);
    end
    nvec++;
    if (lat !== 1 + 1 + 3 * 2) begin nerr++; $display("FAIL start_busy_latency: got %0d required 8", lat); end
  endtask
  task automatic test_random;
    int lat, n, gap;
    logic [7:0] r, ew; logic [3:0] ed, ei; logic ef;
    for (int t = 0; t < 30; t++) begin
      n = $urandom_range(0, 15); gap = $urandom_range(0, 2); r = 8'($urandom);
      for (int i = 0; i < 16; i++) w[i] = ($urandom_range(0, 3) == 0) ? r ^ 8'(1 << $urandom_range(0, 7)) : 8'($urandom);
      model(r, n, ew, ed, ei, ef);
      run(r, n, gap, 0, lat);
      nvec++;
      if ({best_word, best_dist, best_index, found} !== {ew, ed, ei, ef}) begin
        nerr++; $display("FAIL random_%0d: word=%h dist=%0d idx=%0d found=%b required %h/%0d/%0d/%b", t, best_word, best_dist, best_index, found, ew, ed, ei, ef);
      end
      nvec++;
      if (lat !== (n == 0 ? 1 : 2 + (n - 1) * (gap + 1)) || done_n !== 1) begin
        nerr++; $display("FAIL random_%0d_timing: latency %0d pulses %0d (n=%0d gap=%0d)", t, lat, done_n, n, gap);
      end
      nvec++;
      if ({busy, in_ready, done} !== 3'b000) begin nerr++; $display("FAIL random_%0d_idle: busy/ready/done=%b required 000", t, {busy, in_ready, done}); end
    end
  endtask
  initial begin
    test_reset();
    test_tie();
    test_min();
    test_backpressure();
    test_empty();
    test_reset_mid();
    test_start_busy();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
